eth_tx_scheduler: RTL

Sequencing controller for the Ethernet transmit engine. It collects single-cycle transmit requests from the ARP responder, ICMP responder, motor-state source and AD data source, and grants the TX engine to exactly one source per frame. It issues the matching one-cycle trigger, tracks the frame on the RGMII TX AXI-Stream until its last beat, and enforces an inter-frame gap before the next grant. It sits between the RX-side trigger outputs / application triggers and the trigger inputs of the TX engine.

---
 rtl/eth_tx_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/eth_tx_scheduler.sv
// Ethernet TX scheduler: grants one of four frame sources per frame, follows the frame on the TX
// stream and enforces an inter-frame gap. Optional watchdog: ETH_TX_SCHED_WATCHDOG_EN.
module eth_tx_scheduler #(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       CLK_125M,
  input  logic       SYS_RST,
  input  logic       REQ_ARP,
  input  logic       REQ_ICMP,
  input  logic       REQ_MOTOR,
  input  logic       REQ_AD,
  input  logic       RGMII_TX_VALID,
  input  logic       RGMII_TX_READY,
  input  logic       RGMII_TX_LAST,
  output logic       TRIG_TX_ARP,
  output logic       TRIG_TX_ICMP,
  output logic       TRIG_MOTOR_STATE,
  output logic       TRIG_ETH_TX,
  output logic       TX_BUSY,
  output logic [1:0] GRANT_ID,
  output logic [7:0] COALESCE_CNT,
  output logic       TX_TIMEOUT
);

  typedef enum logic [2:0] {StIdle, StGrant, StWaitFirst, StActive, StGap} state_e;

  localparam logic [15:0] GapLast = 16'(IFG_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  pend_q, trig_q, req, clr;
  logic        rr_q;  // 1: AD preferred next, 0: MOTOR preferred next
  logic        busy_q;
  logic [1:0]  grant_id_q, sel;
  logic [7:0]  coal_q;
  logic [15:0] gap_cnt_q;
  logic        beat, in_frame, hit, frame_done, wd_expire;

  always_comb begin
    req      = {REQ_AD, REQ_MOTOR, REQ_ICMP, REQ_ARP};
    beat     = RGMII_TX_VALID & RGMII_TX_READY;
    in_frame = (state_q == StWaitFirst) || (state_q == StActive);
    clr      = '0;
    if (state_q == StGrant) clr[grant_id_q] = 1'b1;
    hit        = |(req & pend_q & ~clr);
    frame_done = in_frame && ((beat && RGMII_TX_LAST) || wd_expire);
    if (pend_q[0])                    sel = 2'd0;
    else if (pend_q[1])               sel = 2'd1;
    else if (pend_q[2] && pend_q[3])  sel = rr_q ? 2'd3 : 2'd2;
    else if (pend_q[2])               sel = 2'd2;
    else                              sel = 2'd3;
  end

  always_ff @(posedge CLK_125M) begin
    if (SYS_RST) begin
      pend_q <= '0;
      coal_q <= '0;
    end else begin
      pend_q <= (pend_q & ~clr) | req;
      if (hit && (coal_q != 8'hFF)) coal_q <= coal_q + 8'd1;
    end
  end

  always_ff @(posedge CLK_125M) begin
    if (SYS_RST) begin
      state_q    <= StIdle;
      trig_q     <= '0;
      busy_q     <= 1'b0;
      grant_id_q <= 2'd0;
      rr_q       <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      trig_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (|pend_q) begin
            state_q     <= StGrant;
            trig_q[sel] <= 1'b1;
            busy_q      <= 1'b1;
            grant_id_q  <= sel;
            if (sel[1]) rr_q <= ~sel[0];
          end
        end
        StGrant:     state_q <= StWaitFirst;
        StWaitFirst: if (beat) state_q <= StActive;
        StActive:    ;
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
      // A zero-length gap goes straight back to IDLE
      if (frame_done) begin
        gap_cnt_q <= '0;
        if (IFG_CYCLES == 0) begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end else begin
          state_q <= StGap;
        end
      end
    end
  end

`ifdef ETH_TX_SCHED_WATCHDOG_EN
  localparam logic [15:0] WdLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q;  // cycles since the grant or the latest beat
  logic        timeout_q;

  assign wd_expire = in_frame && !beat && (wd_q == WdLast);

  always_ff @(posedge CLK_125M) begin
    if (SYS_RST) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire;
      if (state_q == StIdle)    wd_q <= '0;
      else if (in_frame && beat) wd_q <= 16'd1;
      else                      wd_q <= wd_q + 16'd1;
    end
  end

  assign TX_TIMEOUT = timeout_q;
`else
  assign wd_expire  = 1'b0;
  assign TX_TIMEOUT = 1'b0;
`endif

  assign TRIG_TX_ARP      = trig_q[0];
  assign TRIG_TX_ICMP     = trig_q[1];
  assign TRIG_MOTOR_STATE = trig_q[2];
  assign TRIG_ETH_TX      = trig_q[3];
  assign TX_BUSY          = busy_q;
  assign GRANT_ID         = grant_id_q;
  assign COALESCE_CNT     = coal_q;

endmodule
